bus_initiator: RTL and testbench
================================

// Module: bus_initiator
// PURPOSE
//  Requester-side endpoint for the shared 8-bit system bus owned by busctl.
//  Accepts read/write requests from a CPU domain over a valid/ready channel and queues them.
//  Drives busctl's write_en/addr_in/data_in, captures busctl's data_out after a fixed read latency,
//  and returns in-order responses over a second valid/ready channel.
// PARAMETERS
//  ADDR_W    8  width of the bus address
//  DATA_W    8  width of the bus data
//  READ_LAT  1  cycles from the ISSUE cycle to the read-data sample edge; >=1
//  QDEPTH    4  request queue entries; power of 2, >=2
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       queue can accept; equals !full
//  req_write    in   1       1=write, 0=read
//  req_addr     in   ADDR_W  request address
//  req_wdata    in   DATA_W  write data; ignored for reads
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       consumer accepts the response
//  rsp_write    out  1       echo of the completed request's req_write
//  rsp_rdata    out  DATA_W  read data; 0 for write acks
//  bus_write_en out  1       to busctl write_en
//  bus_addr     out  ADDR_W  to busctl addr_in
//  bus_wdata    out  DATA_W  to busctl data_in
//  bus_rdata    in   DATA_W  from busctl data_out
//  busy         out  1       state!=IDLE or queue non-empty
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; queue empty; state IDLE; latency counter 0.
//  Queue: push on req_valid&&req_ready. A push and a pop in the same cycle are legal.
//   There is no bypass: a request is always written to the queue first.
//   Pointers wrap modulo QDEPTH. The count is $clog2(QDEPTH)+1 bits wide.
//   req_ready drops in the cycle in which count==QDEPTH.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE : if the queue is non-empty, pop the head into the op register and go to ISSUE.
//   ISSUE: exactly 1 cycle; bus_addr=op.addr.
//          For a write: bus_write_en=1, bus_wdata=op.wdata, next state RESP.
//          For a read: next state WAIT, with the counter loaded to READ_LAT.
//   WAIT : the counter decrements each cycle. On the edge where the counter==1, register
//          bus_rdata into rsp_rdata and go to RESP.
//   RESP : rsp_valid=1; rsp_write and rsp_rdata are held stable until accepted.
//          On rsp_ready: if the queue is non-empty, pop and go to ISSUE; otherwise go to IDLE.
//  Outside ISSUE, bus_write_en=0, bus_addr=0 and bus_wdata=0, so the bus is idle-safe.
//  Latency (READ_LAT=1), counting the accept cycle as cycle 0:
//   Read : cycle 1 IDLE pop, cycle 2 ISSUE, cycle 3 WAIT (sample), cycle 4 rsp_valid.
//   Write: cycle 1 IDLE pop, cycle 2 ISSUE (write_en), cycle 3 rsp_valid.
//  Back-to-back: with rsp_ready held at 1, consecutive ops have no IDLE bubble (RESP->ISSUE).
//  Strict in-order operation: one outstanding bus op at a time.
//  Response back-pressure does not stop the queue from accepting new requests until it is full.
//  Reset asserted mid-operation: on the next edge every register returns to its reset value.
//   Queued requests are flushed and any pending response is dropped.
//   bus_write_en is 0 in the cycle following the reset edge.
//  Parameters violating READ_LAT>=1 or QDEPTH=2^n are rejected by an elaboration-time check.
// STRUCTURE
//  Package a3_bus_pkg holds:
//   - BUS_ADDR_W/BUS_DATA_W localparams (8/8);
//   - typedef bus_req_t {write, addr, wdata};
//   - typedef enum bus_init_state_t {IDLE, ISSUE, WAIT, RESP}.
//  Sub-module bus_req_fifo(WIDTH=$bits(bus_req_t), DEPTH=QDEPTH):
//   - sync FIFO with push/pop/full/empty/count;
//   - it is the only storage of requests.
//  The FSM, latency counter and response register live in bus_initiator.
// TESTING
//  T1 read: after reset, push read addr=0x12; busctl model returns 0xA5 for it.
//     Expect: bus_addr=0x12 with write_en=0 in cycle 2; rsp_valid in cycle 4 with rsp_rdata=0xA5, rsp_write=0.
//  T2 write: push write addr=0x34 data=0x5C.
//     Expect: exactly one cycle with write_en=1, addr=0x34, wdata=0x5C; then a write ack with rsp_write=1, rsp_rdata=0.
//  T3 full: hold rsp_ready=0 and push 5 requests.
//     Expect: req_ready=0 after 4 queued plus 1 in flight; release rsp_ready and all 5 responses come back in order.
//  T4 streaming: keep rsp_ready=1 and queue W(0x01,0x11), R(0x01), W(0x02,0x22).
//     Expect: ISSUE cycles are spaced with no IDLE cycle between; the read returns 0x11.
//  T5 reset mid-WAIT: assert reset for 1 cycle during a read.
//     Expect: rsp_valid never rises, queue empty, busy=0, bus outputs 0 on the next cycle.
//  T6 READ_LAT=3 build: read returns its data with rsp_valid in cycle 6.
//     Expect: bus_rdata is sampled exactly 3 cycles after ISSUE, and a value changed one cycle early is not captured.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// Shared types for the requester-side bus initiator: request record and FSM states.
package a3_bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 8;

    typedef struct packed {
        logic                  write;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bus_init_state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Request channel, response channel and busctl-facing bus bundled for the initiator.
interface bus_initiator_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;

    logic              bus_write_en;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    logic              busy;

    // Initiator's own view of the bundle.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata,
        input  rsp_ready,
        output bus_write_en, bus_addr, bus_wdata,
        input  bus_rdata,
        output busy
    );

    // Environment view: CPU side plus busctl.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata,
        output rsp_ready,
        input  bus_write_en, bus_addr, bus_wdata,
        output bus_rdata,
        input  busy
    );
endinterface

// File: rtl/bus_initiator_req_fifo.sv
// Synchronous show-ahead FIFO holding pending bus requests; the only request storage.
module bus_req_fifo
    import a3_bus_pkg::*;
#(
    parameter int WIDTH = $bits(bus_req_t),
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("bus_req_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next-state for storage, pointers (wrapping at DEPTH) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_initiator.sv
// Requester endpoint for the busctl bus: queues CPU requests, issues one bus op at a time,
// and returns in-order responses.
module bus_initiator
    import a3_bus_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int READ_LAT = 1,
    parameter int QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    bus_initiator_if.master  bif
);
    localparam int REQ_W = $bits(bus_req_t);
    localparam int LAT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    if (READ_LAT < 1 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 ||
        ADDR_W != BUS_ADDR_W || DATA_W != BUS_DATA_W) begin : g_param_check
        $error("bus_initiator: illegal READ_LAT/QDEPTH/width parameters");
    end

    bus_init_state_t       state_q, state_d;
    bus_req_t              op_q, op_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [BUS_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  bus_write_en_q, bus_write_en_d;
    logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    logic                    fifo_push_s;
    logic                    fifo_pop_s;
    logic [REQ_W-1:0]        fifo_rdata_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [$clog2(QDEPTH):0] fifo_count_s;
    bus_req_t                head_s;
    bus_req_t                in_req_s;

    assign in_req_s    = '{write: bif.req_write, addr: bif.req_addr, wdata: bif.req_wdata};
    assign fifo_push_s = bif.req_valid && !fifo_full_s;
    assign head_s      = bus_req_t'(fifo_rdata_s);

    bus_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .wdata (in_req_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // FSM next state; bus drive values are prepared one edge early so the bus pins are flops.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cnt_d          = cnt_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_write_d    = rsp_write_q;
        rsp_rdata_d    = rsp_rdata_q;
        bus_write_en_d = 1'b0;
        bus_addr_d     = '0;
        bus_wdata_d    = '0;
        fifo_pop_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_d    = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (op_q.write) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_W'(READ_LAT);
                end
            end
            WAIT: begin
                if (cnt_q == LAT_W'(1)) begin
                    state_d     = RESP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = bif.bus_rdata;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (bif.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = '0;
                    if (!fifo_empty_s) begin
                        fifo_pop_s = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Whatever leaves the queue is the op that the next ISSUE cycle drives onto the bus.
        if (fifo_pop_s) begin
            op_d           = head_s;
            bus_write_en_d = head_s.write;
            bus_addr_d     = head_s.addr;
            bus_wdata_d    = head_s.write ? head_s.wdata : '0;
        end else begin
            op_d = op_q;
        end
    end

    // FSM, operation, latency counter, response and bus output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= '0;
            cnt_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_write_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            bus_write_en_q <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_write_q    <= rsp_write_d;
            rsp_rdata_q    <= rsp_rdata_d;
            bus_write_en_q <= bus_write_en_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
        end
    end

    assign bif.req_ready    = !fifo_full_s;
    assign bif.rsp_valid    = rsp_valid_q;
    assign bif.rsp_write    = rsp_write_q;
    assign bif.rsp_rdata    = rsp_rdata_q;
    assign bif.bus_write_en = bus_write_en_q;
    assign bif.bus_addr     = bus_addr_q;
    assign bif.bus_wdata    = bus_wdata_q;
    assign bif.busy         = (state_q != IDLE) || (fifo_count_s != '0);

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: in-order response/write scoreboard plus per-cycle timing records.
module tb_bus_initiator;

    typedef struct packed { logic w; logic [7:0] d; } rsp_t;
    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_initiator_if #(.ADDR_W(8), .DATA_W(8)) bif1 ();
    bus_initiator_if #(.ADDR_W(8), .DATA_W(8)) bif3 ();

    bus_initiator #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1), .QDEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .bif(bif1));
    bus_initiator #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3), .QDEPTH(4)) u_dut3 (
        .clk(clk), .reset(reset), .bif(bif3));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a == 8'h12) return 8'hA5;
        else return a ^ 8'h5A;
    endfunction

    // busctl model: synchronous write, registered read of addr_in.
    logic [7:0] bus_mem [256];
    bit         bus_written [256];
    always @(posedge clk) begin
        if (bif1.bus_write_en) begin
            bus_mem[bif1.bus_addr]     <= bif1.bus_wdata;
            bus_written[bif1.bus_addr] <= 1'b1;
        end
        bif1.bus_rdata <= bus_written[bif1.bus_addr] ? bus_mem[bif1.bus_addr] : init_val(bif1.bus_addr);
    end

    logic [7:0] rd3 = 8'h00;
    assign bif3.bus_rdata = rd3;

    // Reference model: program-order memory and in-order expectation queues.
    logic [7:0]   model_mem [256];
    bit           model_written [256];
    rsp_t         exp_rsp [$];
    wr_t          exp_wr [$];
    logic [8:0]   rsp_log [$];
    logic         prev_hold = 1'b0;
    logic [9:0]   prev_val = 10'd0;

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return model_written[a] ? model_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_rsp.delete();
            exp_wr.delete();
            prev_hold = 1'b0;
        end else begin
            if (bif1.req_valid && bif1.req_ready) begin
                if (bif1.req_write) begin
                    model_mem[bif1.req_addr]     = bif1.req_wdata;
                    model_written[bif1.req_addr] = 1'b1;
                    exp_wr.push_back('{a: bif1.req_addr, d: bif1.req_wdata});
                    exp_rsp.push_back('{w: 1'b1, d: 8'h00});
                end else begin
                    exp_rsp.push_back('{w: 1'b0, d: model_rd(bif1.req_addr)});
                end
            end
            if (prev_hold)
                chk("rsp_hold", 32'({bif1.rsp_valid, bif1.rsp_write, bif1.rsp_rdata}), 32'(prev_val));
            if (bif1.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("rsp_write", 32'(bif1.rsp_write), 32'(exp_rsp[0].w));
                    chk("rsp_rdata", 32'(bif1.rsp_rdata), 32'(exp_rsp[0].d));
                    if (bif1.rsp_ready) begin
                        rsp_log.push_back({bif1.rsp_write, bif1.rsp_rdata});
                        void'(exp_rsp.pop_front());
                    end
                end
            end
            prev_hold = bif1.rsp_valid && !bif1.rsp_ready;
            prev_val  = {bif1.rsp_valid, bif1.rsp_write, bif1.rsp_rdata};
            if (bif1.bus_write_en) begin
                if (exp_wr.size() == 0) begin
                    chk("bus_write_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("bus_write_addr", 32'(bif1.bus_addr), 32'(exp_wr[0].a));
                    chk("bus_write_data", 32'(bif1.bus_wdata), 32'(exp_wr[0].d));
                    void'(exp_wr.pop_front());
                end
            end else begin
                chk("bus_wdata_idle", 32'(bif1.bus_wdata), 32'd0);
            end
        end
    end

    // Per-cycle recorder, indexed relative to the test's cycle 0.
    int cyc_cnt = 0;
    int t0 = 1000000;
    int rec_k;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic       o_rv [64], o_rw [64], o_we [64], o_rr [64], o_busy [64], o3_rv [64];
    logic [7:0] o_rd [64], o_addr [64], o_wd [64], o3_rd [64], o3_addr [64];
    always @(negedge clk) begin
        rec_k = cyc_cnt - t0;
        if (rec_k >= 0 && rec_k < 64) begin
            o_rv[rec_k]    = bif1.rsp_valid;
            o_rw[rec_k]    = bif1.rsp_write;
            o_rd[rec_k]    = bif1.rsp_rdata;
            o_we[rec_k]    = bif1.bus_write_en;
            o_addr[rec_k]  = bif1.bus_addr;
            o_wd[rec_k]    = bif1.bus_wdata;
            o_rr[rec_k]    = bif1.req_ready;
            o_busy[rec_k]  = bif1.busy;
            o3_rv[rec_k]   = bif3.rsp_valid;
            o3_rd[rec_k]   = bif3.rsp_rdata;
            o3_addr[rec_k] = bif3.bus_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req1(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        bif1.req_valid = v;
        bif1.req_write = w;
        bif1.req_addr  = a;
        bif1.req_wdata = d;
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!bif1.busy && !bif3.busy) break;
            step();
        end
        chk({name, "_drain"}, 32'(bif1.busy || bif3.busy), 32'd0);
        chk({name, "_rsp_left"}, 32'(exp_rsp.size()), 32'd0);
        chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    logic [7:0] t3_w [5] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0};
    logic [7:0] t3_a [5] = '{8'h40, 8'h40, 8'h41, 8'h12, 8'h41};
    logic [7:0] t3_d [5] = '{8'h66, 8'h00, 8'h77, 8'h00, 8'h00};
    logic [8:0] t3_exp [5] = '{9'h100, 9'h066, 9'h100, 9'h0A5, 9'h077};

    initial begin
        int n;
        int base;
        req1(1'b0, 1'b0, 8'h00, 8'h00);
        bif1.rsp_ready = 1'b1;
        bif3.req_valid = 1'b0; bif3.req_write = 1'b0; bif3.req_addr = 8'h00; bif3.req_wdata = 8'h00;
        bif3.rsp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bif1.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bif1.rsp_valid), 32'd0);
        chk("rst_rsp_write", 32'(bif1.rsp_write), 32'd0);
        chk("rst_rsp_rdata", 32'(bif1.rsp_rdata), 32'd0);
        chk("rst_busy", 32'(bif1.busy), 32'd0);
        chk("rst_bus_we", 32'(bif1.bus_write_en), 32'd0);
        chk("rst_bus_addr", 32'(bif1.bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bif1.bus_wdata), 32'd0);
        step();

        // T1: single read
        t0 = cyc_cnt;
        req1(1'b1, 1'b0, 8'h12, 8'h00);
        step();
        req1(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (7) step();
        chk("t1_busy_c1", 32'(o_busy[1]), 32'd1);
        chk("t1_addr_c2", 32'(o_addr[2]), 32'h12);
        chk("t1_we_c2", 32'(o_we[2]), 32'd0);
        chk("t1_rv_c3", 32'(o_rv[3]), 32'd0);
        chk("t1_rv_c4", 32'(o_rv[4]), 32'd1);
        chk("t1_rd_c4", 32'(o_rd[4]), 32'hA5);
        chk("t1_rw_c4", 32'(o_rw[4]), 32'd0);
        chk("t1_rv_c5", 32'(o_rv[5]), 32'd0);
        drain("t1", 20);

        // T2: single write
        t0 = cyc_cnt;
        req1(1'b1, 1'b1, 8'h34, 8'h5C);
        step();
        req1(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (7) step();
        n = 0;
        for (int k = 0; k < 8; k++) if (o_we[k]) n++;
        chk("t2_we_pulses", 32'(n), 32'd1);
        chk("t2_we_c2", 32'(o_we[2]), 32'd1);
        chk("t2_addr_c2", 32'(o_addr[2]), 32'h34);
        chk("t2_wd_c2", 32'(o_wd[2]), 32'h5C);
        chk("t2_rv_c3", 32'(o_rv[3]), 32'd1);
        chk("t2_rw_c3", 32'(o_rw[3]), 32'd1);
        chk("t2_rd_c3", 32'(o_rd[3]), 32'h00);
        drain("t2", 20);

        // T3: fill the queue under response back-pressure
        base = rsp_log.size();
        t0 = cyc_cnt;
        bif1.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req1(1'b1, t3_w[i][0], t3_a[i], t3_d[i]);
            step();
        end
        req1(1'b1, 1'b0, 8'h77, 8'h00);
        repeat (2) step();
        req1(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        bif1.rsp_ready = 1'b1;
        drain("t3", 80);
        chk("t3_rr_c4", 32'(o_rr[4]), 32'd1);
        chk("t3_rr_c5", 32'(o_rr[5]), 32'd0);
        chk("t3_rr_c6", 32'(o_rr[6]), 32'd0);
        chk("t3_rv_c3", 32'(o_rv[3]), 32'd1);
        chk("t3_rv_c7", 32'(o_rv[7]), 32'd1);
        chk("t3_count", 32'(rsp_log.size() - base), 32'd5);
        for (int i = 0; i < 5; i++)
            if (base + i < rsp_log.size()) chk("t3_order", 32'(rsp_log[base + i]), 32'(t3_exp[i]));

        // T4: streaming with rsp_ready held high
        t0 = cyc_cnt;
        req1(1'b1, 1'b1, 8'h01, 8'h11);
        step();
        req1(1'b1, 1'b0, 8'h01, 8'h00);
        step();
        req1(1'b1, 1'b1, 8'h02, 8'h22);
        step();
        req1(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (9) step();
        chk("t4_we_c2", 32'(o_we[2]), 32'd1);
        chk("t4_addr_c2", 32'(o_addr[2]), 32'h01);
        chk("t4_rv_c3", 32'(o_rv[3]), 32'd1);
        chk("t4_addr_c4", 32'(o_addr[4]), 32'h01);
        chk("t4_we_c4", 32'(o_we[4]), 32'd0);
        chk("t4_rv_c6", 32'(o_rv[6]), 32'd1);
        chk("t4_rd_c6", 32'(o_rd[6]), 32'h11);
        chk("t4_we_c7", 32'(o_we[7]), 32'd1);
        chk("t4_addr_c7", 32'(o_addr[7]), 32'h02);
        chk("t4_wd_c7", 32'(o_wd[7]), 32'h22);
        chk("t4_rv_c8", 32'(o_rv[8]), 32'd1);
        n = 0;
        for (int k = 1; k <= 8; k++) if (o_busy[k]) n++;
        chk("t4_no_idle_gap", 32'(n), 32'd8);
        drain("t4", 20);

        // T5: reset during the WAIT cycle of a read
        t0 = cyc_cnt;
        req1(1'b1, 1'b0, 8'h12, 8'h00);
        step();
        req1(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (7) step();
        chk("t5_addr_c2", 32'(o_addr[2]), 32'h12);
        chk("t5_busy_c3", 32'(o_busy[3]), 32'd1);
        chk("t5_busy_c4", 32'(o_busy[4]), 32'd0);
        chk("t5_rr_c4", 32'(o_rr[4]), 32'd1);
        chk("t5_we_c4", 32'(o_we[4]), 32'd0);
        chk("t5_addr_c4", 32'(o_addr[4]), 32'd0);
        n = 0;
        for (int k = 0; k <= 10; k++) if (o_rv[k]) n++;
        chk("t5_rv_never", 32'(n), 32'd0);
        drain("t5", 20);

        // T6: READ_LAT=3 instance samples bus_rdata only in the third cycle after ISSUE
        t0 = cyc_cnt;
        bif3.req_valid = 1'b1; bif3.req_write = 1'b0; bif3.req_addr = 8'h20;
        rd3 = 8'h00;
        step();
        bif3.req_valid = 1'b0;
        repeat (2) step();
        rd3 = 8'h11; step();
        rd3 = 8'h22; step();
        rd3 = 8'h33; step();
        rd3 = 8'h44;
        repeat (4) step();
        chk("t6_addr_c2", 32'(o3_addr[2]), 32'h20);
        chk("t6_rv_c5", 32'(o3_rv[5]), 32'd0);
        chk("t6_rv_c6", 32'(o3_rv[6]), 32'd1);
        chk("t6_rd_c6", 32'(o3_rd[6]), 32'h33);
        chk("t6_rv_c7", 32'(o3_rv[7]), 32'd0);
        drain("t6", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
